match_ctrl: RTL and testbench

- Parametrised successor to the game control FSM: owns the card grid, cursor, selection and match/removal logic for a COLS x ROWS board.
- Generalised to MATCH_N cards per match (2 = pairs, 3 = triples), with a timed reveal before judging and explicit win/new-game sequencing.
- Sits between the map generator (requests and loads a fresh map) and the VGA and seven-segment display blocks (drives map, cursor, selection and score).

---
 rtl/match_ctrl_pkg.sv | 9 +
 rtl/match_ctrl_btn_edge.sv | 21 ++
 rtl/match_ctrl.sv | 157 +++++++++++++++
 tb/tb_match_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/match_ctrl_pkg.sv
// match_ctrl_pkg: controller state encoding, empty-card value and grid helper shared with the VGA reveal highlight
package match_ctrl_pkg;
  typedef enum logic [2:0] {REQ, WAIT, PLAY, SHOW, CHECK, WIN} ctrlState;
  localparam int EMPTY_CARD = 0;
  // Step a row or column coordinate by +-1 and wrap it inside its span.
  function automatic int wrapStep(input int pos, input int step, input int span);
    return (pos + step + span) % span;
  endfunction
endpackage

// File: rtl/match_ctrl_btn_edge.sv
// btn_edge: registered rising-edge detector for a bank of already-debounced button levels
module btn_edge #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);
  logic [W-1:0] prev;
  // rise is high for exactly the one cycle after a 0->1 level transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= '0;
      rise <= '0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
    end
  end
endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: card-matching game controller (grid, cursor, selection, timed reveal, removal, win); MATCH_MISS_COUNT_EN adds miss_count
module match_ctrl
  import match_ctrl_pkg::*;
#(
  parameter int COLS        = 4,
  parameter int ROWS        = 4,
  parameter int CARD_W      = 4,
  parameter int MATCH_N     = 2,
  parameter int SHOW_CYCLES = 50000000,
  parameter int SCORE_W     = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    btn_u,
  input  logic                                    btn_d,
  input  logic                                    btn_l,
  input  logic                                    btn_r,
  input  logic                                    btn_s,
  input  logic [COLS*ROWS*CARD_W-1:0]             gen_map,
  input  logic                                    gen_done,
  output logic                                    map_req,
  output logic [COLS*ROWS*CARD_W-1:0]             logic_map,
  output logic [$clog2(COLS*ROWS)-1:0]            cursor,
  output logic [MATCH_N*$clog2(COLS*ROWS)-1:0]    sel_list,
  output logic [$clog2(MATCH_N+1)-1:0]            sel_count,
  output logic [SCORE_W-1:0]                      removed,
  output logic                                    revealing,
  output logic                                    game_won
`ifdef MATCH_MISS_COUNT_EN
  ,output logic [7:0]                             miss_count
`endif
);
  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = $clog2(CELLS);
  localparam int TMR_W = SHOW_CYCLES > 1 ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  ctrlState state, stateNext;
  logic [4:0] rise;
  logic seenLow, selHit, cellEmpty, selAdd, facesEqual, boardClear;
  logic [TMR_W-1:0] timer;
  logic [IDX_W-1:0] cursorNext;
  logic [CELLS*CARD_W-1:0] mapJudged;
  logic [SCORE_W:0] removedSum;
  btn_edge #(.W(5)) uEdge (
    .clk   (clk),
    .rst   (rst),
    .level ({btn_s, btn_u, btn_d, btn_l, btn_r}),
    .rise  (rise)
  );
  assign cellEmpty  = logic_map[int'(cursor)*CARD_W +: CARD_W] == CARD_W'(EMPTY_CARD);
  assign selAdd     = rise[4] && !cellEmpty && !selHit;
  assign removedSum = {1'b0, removed} + (SCORE_W+1)'(MATCH_N);
  assign revealing  = state == SHOW;
  assign game_won   = state == WIN;
  // Cursor target for the highest-priority edge (S > U > D > L > R); select leaves it in place
  always_comb begin
    int col, row;
    col = int'(cursor) % COLS;
    row = int'(cursor) / COLS;
    if (rise[4]) row = row;
    else if (rise[3]) row = wrapStep(row, -1, ROWS);
    else if (rise[2]) row = wrapStep(row, 1, ROWS);
    else if (rise[1]) col = wrapStep(col, -1, COLS);
    else if (rise[0]) col = wrapStep(col, 1, COLS);
    cursorNext = IDX_W'(row * COLS + col);
  end
  // Is the cursor cell already in one of the valid selection slots?
  always_comb begin
    selHit = 1'b0;
    for (int i = 0; i < MATCH_N; i++)
      if (i < int'(sel_count) && sel_list[i*IDX_W +: IDX_W] == cursor) selHit = 1'b1;
  end
  // Judge a full selection: equal faces get removed; also report whether the board would then be empty
  always_comb begin
    logic [CARD_W-1:0] face0;
    face0 = logic_map[int'(sel_list[IDX_W-1:0])*CARD_W +: CARD_W];
    facesEqual = 1'b1;
    mapJudged = logic_map;
    for (int i = 1; i < MATCH_N; i++)
      if (logic_map[int'(sel_list[i*IDX_W +: IDX_W])*CARD_W +: CARD_W] != face0) facesEqual = 1'b0;
    if (facesEqual)
      for (int i = 0; i < MATCH_N; i++)
        mapJudged[int'(sel_list[i*IDX_W +: IDX_W])*CARD_W +: CARD_W] = CARD_W'(EMPTY_CARD);
    boardClear = mapJudged == '0;
  end
  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      REQ:     stateNext = WAIT;
      WAIT:    stateNext = gen_done && seenLow ? PLAY : WAIT;
      PLAY:    stateNext = selAdd && int'(sel_count) == MATCH_N - 1 ? SHOW : PLAY;
      SHOW:    stateNext = int'(timer) == SHOW_CYCLES - 1 ? CHECK : SHOW;
      CHECK:   stateNext = boardClear ? WIN : PLAY;
      WIN:     stateNext = rise[4] ? REQ : WIN;
      default: stateNext = REQ;
    endcase
  end
  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= REQ;
    else state <= stateNext;
  end
  // Board, cursor, selection, timer and score registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      map_req   <= 1'b0;
      seenLow   <= 1'b0;
      timer     <= '0;
      logic_map <= '0;
      cursor    <= '0;
      sel_list  <= '0;
      sel_count <= '0;
      removed   <= '0;
`ifdef MATCH_MISS_COUNT_EN
      miss_count <= '0;
`endif
    end else begin
      map_req <= state == REQ;
      case (state)
        REQ: seenLow <= 1'b0;
        WAIT: begin
          if (!gen_done) seenLow <= 1'b1;
          if (gen_done && seenLow) begin
            logic_map <= gen_map;
            cursor    <= '0;
            removed   <= '0;
            sel_list  <= '0;
            sel_count <= '0;
`ifdef MATCH_MISS_COUNT_EN
            miss_count <= '0;
`endif
          end
        end
        PLAY: begin
          cursor <= cursorNext;
          timer  <= '0;
          if (selAdd) begin
            sel_list[int'(sel_count)*IDX_W +: IDX_W] <= cursor;
            sel_count <= sel_count + 1'b1;
          end
        end
        SHOW: timer <= timer + 1'b1;
        CHECK: begin
          logic_map <= mapJudged;
          sel_list  <= '0;
          sel_count <= '0;
          if (facesEqual) removed <= removedSum[SCORE_W] ? SCORE_MAX : removedSum[SCORE_W-1:0];
`ifdef MATCH_MISS_COUNT_EN
          if (!facesEqual && miss_count != 8'hFF) miss_count <= miss_count + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_match_ctrl.sv
// tb_match_ctrl: directed bench for match_ctrl on a 4x4 board, pairs, 4-cycle reveal, with a board-level reference model
module tb_match_ctrl;
  localparam int COLS = 4, ROWS = 4, CELLS = 16, MN = 2, SHOW = 4;
  localparam logic [4:0] BS = 5'b10000, BU = 5'b01000, BD = 5'b00100, BL = 5'b00010, BR = 5'b00001;
  logic clk = 0, rst = 0;
  logic btn_u = 0, btn_d = 0, btn_l = 0, btn_r = 0, btn_s = 0;
  logic [63:0] gen_map = '1;
  logic gen_done = 1;
  logic map_req, revealing, game_won;
  logic [63:0] logic_map;
  logic [3:0] cursor;
  logic [7:0] sel_list;
  logic [1:0] sel_count;
  logic [7:0] removed;
`ifdef MATCH_MISS_COUNT_EN
  logic [7:0] miss_count;
`endif
  match_ctrl #(.COLS(COLS), .ROWS(ROWS), .CARD_W(4), .MATCH_N(MN), .SHOW_CYCLES(SHOW), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r), .btn_s(btn_s),
    .gen_map(gen_map), .gen_done(gen_done), .map_req(map_req), .logic_map(logic_map), .cursor(cursor),
    .sel_list(sel_list), .sel_count(sel_count), .removed(removed), .revealing(revealing), .game_won(game_won)
`ifdef MATCH_MISS_COUNT_EN
    , .miss_count(miss_count)
`endif
  );
  always #5 clk = ~clk;
  int nCmp = 0, nBad = 0, mapReqCount = 0, revealCount = 0;
  logic chk = 0, holdReveal = 0;
  logic [63:0] pat = 64'h8877_6655_4433_2211;
  int mMap [CELLS];
  int mSel [$];
  int mCursor = 0, mRemoved = 0, mMiss = 0;
  logic mReveal = 0, mWon = 0;
  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] expMap();
    logic [63:0] v = '0;
    for (int i = 0; i < CELLS; i++) v[i*4 +: 4] = 4'(mMap[i]);
    return v;
  endfunction
  function automatic logic [7:0] expSel();
    logic [7:0] v = '0;
    foreach (mSel[k]) v[k*4 +: 4] = 4'(mSel[k]);
    return v;
  endfunction
  // Per-cycle comparison against the model whenever the board is in a settled state
  always @(negedge clk) begin
    if (map_req) mapReqCount++;
    if (revealing) revealCount++;
    if (chk) begin
      cmp("logic_map", 128'(logic_map), 128'(expMap()));
      cmp("cursor", 128'(cursor), 128'(mCursor));
      cmp("sel_list", 128'(sel_list), 128'(expSel()));
      cmp("sel_count", 128'(sel_count), 128'(mSel.size()));
      cmp("removed", 128'(removed), 128'(mRemoved));
      cmp("revealing", 128'(revealing), 128'(mReveal));
      cmp("game_won", 128'(game_won), 128'(mWon));
`ifdef MATCH_MISS_COUNT_EN
      cmp("miss_count", 128'(miss_count), 128'(mMiss));
`endif
    end
  end
  // Model: apply one button press using the game rules on rows/columns
  task automatic modelPress(input logic [4:0] m);
    int r, c;
    bit dup;
    r = mCursor / COLS;
    c = mCursor % COLS;
    if (mWon) begin
      if (m[4]) mWon = 0;
    end else if (m[4]) begin
      dup = 0;
      foreach (mSel[k]) if (mSel[k] == mCursor) dup = 1;
      if (mMap[mCursor] != 0 && !dup) begin
        mSel.push_back(mCursor);
        if (mSel.size() == MN) mReveal = 1;
      end
    end else begin
      if (m[3]) r = (r + ROWS - 1) % ROWS;
      else if (m[2]) r = (r + 1) % ROWS;
      else if (m[1]) c = (c + COLS - 1) % COLS;
      else if (m[0]) c = (c + 1) % COLS;
      mCursor = r * COLS + c;
    end
  endtask
  task automatic modelJudge();
    bit same = 1;
    bit empty = 1;
    foreach (mSel[k]) if (mMap[mSel[k]] != mMap[mSel[0]]) same = 0;
    if (same) begin
      foreach (mSel[k]) mMap[mSel[k]] = 0;
      mRemoved = mRemoved + MN > 255 ? 255 : mRemoved + MN;
    end else mMiss = mMiss == 255 ? 255 : mMiss + 1;
    mSel.delete();
    for (int i = 0; i < CELLS; i++) if (mMap[i] != 0) empty = 0;
    mWon = empty;
  endtask
  task automatic press(input logic [4:0] m);
    @(posedge clk); #1;
    chk = 0;
    {btn_s, btn_u, btn_d, btn_l, btn_r} = m;
    @(posedge clk); #1;
    {btn_s, btn_u, btn_d, btn_l, btn_r} = '0;
    @(posedge clk); #1;
    modelPress(m);
    chk = 1;
    if (mReveal && !holdReveal) begin
      for (int k = 1; k < SHOW; k++) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      mReveal = 0;
      @(posedge clk); #1;
      modelJudge();
    end
  endtask
  task automatic goSel(input int target);
    while (mCursor / COLS != target / COLS) press(BD);
    while (mCursor % COLS != target % COLS) press(BR);
    press(BS);
  endtask
  task automatic loadMap();
    mapReqCount = 0;
    gen_map = '1;
    repeat (3) @(posedge clk);
    #1 gen_done = 0;
    @(posedge clk); #1;
    gen_done = 1;
    gen_map = pat;
    @(posedge clk); #1;
    for (int i = 0; i < CELLS; i++) mMap[i] = int'(pat[i*4 +: 4]);
    mCursor = 0; mRemoved = 0; mMiss = 0; mWon = 0; mReveal = 0;
    mSel.delete();
    chk = 1;
    cmp("map_req_pulses", 128'(mapReqCount), 128'(1));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end
  initial begin
    foreach (mMap[i]) mMap[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_map_req", 128'(map_req), 128'(0));
    cmp("rst_logic_map", 128'(logic_map), 128'(0));
    cmp("rst_cursor", 128'(cursor), 128'(0));
    cmp("rst_sel_list", 128'(sel_list), 128'(0));
    cmp("rst_sel_count", 128'(sel_count), 128'(0));
    cmp("rst_removed", 128'(removed), 128'(0));
    cmp("rst_revealing", 128'(revealing), 128'(0));
    cmp("rst_game_won", 128'(game_won), 128'(0));
    rst = 1;
    chk = 1;
    loadMap();
    cmp("load_map_literal", 128'(logic_map), 128'(64'h8877_6655_4433_2211));
    cmp("load_cursor", 128'(cursor), 128'(0));
    press(BU); cmp("wrap_up_0_to_12", 128'(cursor), 128'(12));
    press(BD); cmp("wrap_down_12_to_0", 128'(cursor), 128'(0));
    press(BL); cmp("wrap_left_0_to_3", 128'(cursor), 128'(3));
    press(BR); cmp("wrap_right_3_to_0", 128'(cursor), 128'(0));
    press(BR);
    press(BS);
    press(BS); cmp("dup_select_ignored", 128'(sel_count), 128'(1));
    press(BR);
    revealCount = 0;
    press(BS);
    cmp("miss_reveal_cycles", 128'(revealCount), 128'(SHOW));
    cmp("miss_map_unchanged", 128'(logic_map), 128'(64'h8877_6655_4433_2211));
    cmp("miss_removed", 128'(removed), 128'(0));
    cmp("miss_sel_count", 128'(sel_count), 128'(0));
`ifdef MATCH_MISS_COUNT_EN
    cmp("miss_count_one", 128'(miss_count), 128'(1));
`endif
    press(BL);
    press(BS | BL);
    cmp("s_beats_l_cursor", 128'(cursor), 128'(1));
    cmp("s_beats_l_count", 128'(sel_count), 128'(1));
    press(BL);
    revealCount = 0;
    press(BS);
    cmp("match_reveal_cycles", 128'(revealCount), 128'(SHOW));
    cmp("match_removed", 128'(removed), 128'(2));
    cmp("match_map", 128'(logic_map), 128'(64'h8877_6655_4433_2200));
    cmp("match_sel_count", 128'(sel_count), 128'(0));
    press(BD); press(BR);
    press(BS); press(BS);
    press(BU);
    press(BS);
    cmp("empty_and_dup_ignored", 128'(sel_count), 128'(1));
    cmp("sel_slot0_is_5", 128'(sel_list), 128'(8'h05));
    goSel(4);
    for (int p = 1; p < 8; p++)
      if (p != 2) begin
        goSel(2 * p);
        goSel(2 * p + 1);
      end
    cmp("win_flag", 128'(game_won), 128'(1));
    cmp("win_removed", 128'(removed), 128'(16));
    press(BR);
    cmp("win_cursor_frozen", 128'(cursor), 128'(15));
    press(BS);
    loadMap();
    cmp("restart_removed", 128'(removed), 128'(0));
    cmp("restart_map", 128'(logic_map), 128'(64'h8877_6655_4433_2211));
    holdReveal = 1;
    goSel(0);
    goSel(1);
    holdReveal = 0;
    @(posedge clk); #1;
    cmp("show_before_reset", 128'(revealing), 128'(1));
    chk = 0;
    rst = 0;
    #1;
    cmp("arst_map_req", 128'(map_req), 128'(0));
    cmp("arst_logic_map", 128'(logic_map), 128'(0));
    cmp("arst_cursor", 128'(cursor), 128'(0));
    cmp("arst_sel_list", 128'(sel_list), 128'(0));
    cmp("arst_sel_count", 128'(sel_count), 128'(0));
    cmp("arst_removed", 128'(removed), 128'(0));
    cmp("arst_revealing", 128'(revealing), 128'(0));
    cmp("arst_game_won", 128'(game_won), 128'(0));
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
